// File: rtl/booth_mul_scheduler.sv
// rtl/booth_mul_scheduler.sv - round-robin arbiter/sequencer sharing one Booth multiplier core
// Grants one requester at a time, loads the core, waits WIDTH iterations, captures the product.
module booth_mul_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [2*WIDTH-1:0]       result,
  output logic                     busy,
  output logic                     mul_ready,
  output logic [WIDTH-1:0]         mul_inp1,
  output logic [WIDTH-1:0]         mul_inp2,
  input  logic [WIDTH-1:0]         mul_out0,
  input  logic [WIDTH-1:0]         mul_out1
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPTURE} state_t;

  state_t               state, state_nxt;
  logic [NUM_REQ-1:0]   grant_nxt, done_nxt, elig;
  logic [2*WIDTH-1:0]   result_nxt;
  logic                 busy_nxt, mul_ready_nxt, found;
  logic [WIDTH-1:0]     inp1_nxt, inp2_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     ptr, ptr_nxt, gidx, gidx_nxt, sel, cand;

  // A requester in its done cycle is not eligible, so it cannot be re-granted immediately.
  always_comb begin
    elig  = req & ~done;
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    done_nxt      = '0;
    result_nxt    = result;
    busy_nxt      = busy;
    mul_ready_nxt = 1'b0;
    inp1_nxt      = mul_inp1;
    inp2_nxt      = mul_inp2;
    cnt_nxt       = cnt;
    ptr_nxt       = ptr;
    gidx_nxt      = gidx;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = LOAD;
          grant_nxt     = NUM_REQ'(1) << sel;
          gidx_nxt      = sel;
          busy_nxt      = 1'b1;
          mul_ready_nxt = 1'b1;
          inp1_nxt      = a_in[sel*WIDTH +: WIDTH];
          inp2_nxt      = b_in[sel*WIDTH +: WIDTH];
        end
      end
      LOAD: begin
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        result_nxt = {mul_out0, mul_out1};
        done_nxt   = grant;
        grant_nxt  = '0;
        busy_nxt   = 1'b0;
        ptr_nxt    = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      done      <= '0;
      result    <= '0;
      busy      <= 1'b0;
      mul_ready <= 1'b0;
      mul_inp1  <= '0;
      mul_inp2  <= '0;
      cnt       <= '0;
      ptr       <= '0;
      gidx      <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      done      <= done_nxt;
      result    <= result_nxt;
      busy      <= busy_nxt;
      mul_ready <= mul_ready_nxt;
      mul_inp1  <= inp1_nxt;
      mul_inp2  <= inp2_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      gidx      <= gidx_nxt;
    end
  end

endmodule
